// File: rtl/avmm_reg_slave.sv
// Avalon-MM register slave: ID/version, eight control bytes, live status,
// edge-triggered interrupt flags with mask, scratch register and a command
// strobe that stalls the bus for CMD_BUSY cycles. Reads return in a fixed
// two-cycle pipeline.
module avmm_reg_slave #(
   parameter logic [7:0]  VERSION  = 8'h01,
   parameter int unsigned CMD_BUSY = 4
) (
   input  logic        clk_clk,
   input  logic        reset_reset,
   input  logic [7:0]  avs_s0_address,
   input  logic        avs_s0_read,
   input  logic        avs_s0_write,
   input  logic [7:0]  avs_s0_writedata,
   output logic        avs_s0_waitrequest,
   output logic [7:0]  avs_s0_readdata,
   output logic        avs_s0_readdatavalid,
   output logic [63:0] ctrl_export,
   input  logic [7:0]  status_export,
   input  logic [7:0]  event_export,
   output logic        irq,
   output logic        cmd_strobe,
   output logic [7:0]  cmd_code
);

   localparam logic [7:0] ADDR_ID      = 8'h00;
   localparam logic [7:0] ADDR_VERSION = 8'h01;
   localparam logic [7:0] ADDR_CTRL0   = 8'h02;
   localparam logic [7:0] ADDR_STATUS  = 8'h0A;
   localparam logic [7:0] ADDR_FLAGS   = 8'h0B;
   localparam logic [7:0] ADDR_MASK    = 8'h0C;
   localparam logic [7:0] ADDR_SCRATCH = 8'h0D;
   localparam logic [7:0] ADDR_CMD     = 8'h0E;
   localparam logic [7:0] ID_VALUE     = 8'h5A;
   localparam logic [3:0] BUSY_LOAD    = 4'(CMD_BUSY);

   logic [7:0] ctrl_q [8];
   logic [7:0] flags_q, flags_d, mask_q, scratch_q, status_q, hist_q;
   logic       irq_q, strobe_q;
   logic [7:0] code_q;
   logic [3:0] busy_q, busy_d;

   logic       rd_v1_q, rd_v2_q, rdv_q;
   logic [7:0] rd_d1_q, rd_d2_q, rdata_q;

   logic       wr_acc, rd_acc, ctrl_sel;
   logic [7:0] ctrl_off, rd_mux, flags_clr;
   logic [2:0] ctrl_idx;

   // Stall while in reset or while a command is being processed.
   assign avs_s0_waitrequest = reset_reset | (busy_q != 4'd0);

   // A simultaneous read and write is illegal; the write wins and the read is dropped.
   assign wr_acc = avs_s0_write & ~avs_s0_waitrequest;
   assign rd_acc = avs_s0_read & ~avs_s0_write & ~avs_s0_waitrequest;

   assign ctrl_off = avs_s0_address - ADDR_CTRL0;
   assign ctrl_idx = ctrl_off[2:0];
   assign ctrl_sel = (ctrl_off < 8'd8);

   // Read mux, interrupt flag and busy-counter next-state logic.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      rd_mux    = 8'h00;
      flags_clr = 8'h00;
      busy_d    = busy_q;
      if (ctrl_sel) begin
         rd_mux = ctrl_q[ctrl_idx];
      end else begin
         case (avs_s0_address)
            ADDR_ID:      rd_mux = ID_VALUE;
            ADDR_VERSION: rd_mux = VERSION;
            ADDR_STATUS:  rd_mux = status_q;
            ADDR_FLAGS:   rd_mux = flags_q;
            ADDR_MASK:    rd_mux = mask_q;
            ADDR_SCRATCH: rd_mux = scratch_q;
            default:      rd_mux = 8'h00;
         endcase
      end
      if (wr_acc && avs_s0_address == ADDR_FLAGS) flags_clr = avs_s0_writedata;
      // A new rising edge overrides a simultaneous write-1-to-clear.
      flags_d = (flags_q & ~flags_clr) | (event_export & ~hist_q);
      if (busy_q != 4'd0) busy_d = busy_q - 4'd1;
      if (wr_acc && avs_s0_address == ADDR_CMD) busy_d = BUSY_LOAD;
   end

   // Register file, interrupt logic and command strobe.
   always_ff @(posedge clk_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset_reset) begin
         // NOTE: the control bytes are architectural registers with a defined reset value, so the array is reset.
         for (int i = 0; i < 8; i++) ctrl_q[i] <= 8'h00;
         flags_q   <= 8'h00;
         mask_q    <= 8'h00;
         scratch_q <= 8'h00;
         status_q  <= 8'h00;
         hist_q    <= 8'hFF;
         irq_q     <= 1'b0;
         strobe_q  <= 1'b0;
         code_q    <= 8'h00;
         busy_q    <= 4'd0;
      end else begin
         if (wr_acc && ctrl_sel) ctrl_q[ctrl_idx] <= avs_s0_writedata;
         if (wr_acc && avs_s0_address == ADDR_MASK) mask_q <= avs_s0_writedata;
         if (wr_acc && avs_s0_address == ADDR_SCRATCH) scratch_q <= avs_s0_writedata;
         strobe_q <= wr_acc && (avs_s0_address == ADDR_CMD);
         if (wr_acc && avs_s0_address == ADDR_CMD) code_q <= avs_s0_writedata;
         flags_q  <= flags_d;
         status_q <= status_export;
         hist_q   <= event_export;
         irq_q    <= |(flags_q & mask_q);
         busy_q   <= busy_d;
      end
   end

   // Two-stage read return pipeline; data is captured at acceptance.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         rd_v1_q <= 1'b0;
         rd_v2_q <= 1'b0;
         rdv_q   <= 1'b0;
         rd_d1_q <= 8'h00;
         rd_d2_q <= 8'h00;
         rdata_q <= 8'h00;
      end else begin
         rd_v1_q <= rd_acc;
         rd_d1_q <= rd_mux;
         rd_v2_q <= rd_v1_q;
         rd_d2_q <= rd_d1_q;
         rdv_q   <= rd_v2_q;
         rdata_q <= rd_d2_q;
      end
   end

   // CTRL0 occupies the least significant byte of the export bus.
   always_comb begin
      for (int i = 0; i < 8; i++) ctrl_export[i*8 +: 8] = ctrl_q[i];
   end

   assign avs_s0_readdata      = rdata_q;
   assign avs_s0_readdatavalid = rdv_q;
   assign irq                  = irq_q;
   assign cmd_strobe           = strobe_q;
   assign cmd_code             = code_q;

endmodule

// File: tb/tb_avmm_reg_slave.sv
// Directed bench for avmm_reg_slave: a table of register accesses with
// hand-computed results, plus sequences for back-to-back reads, interrupts,
// command stall, in-flight read data and reset abort.
module tb_avmm_reg_slave;

   logic        clk_clk = 1'b0;
   logic        reset_reset = 1'b1;
   logic [7:0]  avs_s0_address = 8'h00;
   logic        avs_s0_read = 1'b0;
   logic        avs_s0_write = 1'b0;
   logic [7:0]  avs_s0_writedata = 8'h00;
   logic        avs_s0_waitrequest;
   logic [7:0]  avs_s0_readdata;
   logic        avs_s0_readdatavalid;
   logic [63:0] ctrl_export;
   logic [7:0]  status_export = 8'h96;
   logic [7:0]  event_export = 8'h01;
   logic        irq;
   logic        cmd_strobe;
   logic [7:0]  cmd_code;

   int total = 0;
   int bad   = 0;

   avmm_reg_slave #(.VERSION(8'h01), .CMD_BUSY(4)) dut (
      .clk_clk              (clk_clk),
      .reset_reset          (reset_reset),
      .avs_s0_address       (avs_s0_address),
      .avs_s0_read          (avs_s0_read),
      .avs_s0_write         (avs_s0_write),
      .avs_s0_writedata     (avs_s0_writedata),
      .avs_s0_waitrequest   (avs_s0_waitrequest),
      .avs_s0_readdata      (avs_s0_readdata),
      .avs_s0_readdatavalid (avs_s0_readdatavalid),
      .ctrl_export          (ctrl_export),
      .status_export        (status_export),
      .event_export         (event_export),
      .irq                  (irq),
      .cmd_strobe           (cmd_strobe),
      .cmd_code             (cmd_code)
   );

   always #5 clk_clk = ~clk_clk;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      while (avs_s0_waitrequest && n < 20) begin
         tick();
         n++;
      end
      if (avs_s0_waitrequest) check("wait_ready_timeout", 1, 0);
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
      wait_ready();
      avs_s0_write     = 1'b1;
      avs_s0_address   = addr;
      avs_s0_writedata = data;
      tick();
      avs_s0_write = 1'b0;
   endtask

   // Waits for readdatavalid after an acceptance edge; checks latency and data.
   task automatic collect(input string name, input logic [7:0] exp);
      int lat;
      lat = 0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (avs_s0_readdatavalid) begin
            lat = i;
            break;
         end
      end
      check({name, "_lat"}, 64'(lat), 64'd2);
      check({name, "_data"}, {56'h0, avs_s0_readdata}, {56'h0, exp});
   endtask

   task automatic do_read(input string name, input logic [7:0] addr, input logic [7:0] exp);
      wait_ready();
      avs_s0_read    = 1'b1;
      avs_s0_address = addr;
      tick();
      avs_s0_read = 1'b0;
      collect(name, exp);
   endtask

   vec_t vecs [18];
   int   cnt;

   initial begin
      vecs[0]  = '{1'b0, 8'h00, 8'h00, 8'h5A};
      vecs[1]  = '{1'b0, 8'h01, 8'h00, 8'h01};
      vecs[2]  = '{1'b0, 8'h0B, 8'h00, 8'h00}; // level high through reset sets no flag
      vecs[3]  = '{1'b1, 8'h05, 8'hA5, 8'h00};
      vecs[4]  = '{1'b0, 8'h05, 8'h00, 8'hA5};
      vecs[5]  = '{1'b0, 8'h02, 8'h00, 8'h00};
      vecs[6]  = '{1'b1, 8'h0D, 8'h11, 8'h00};
      vecs[7]  = '{1'b0, 8'h0D, 8'h00, 8'h11};
      vecs[8]  = '{1'b0, 8'h0A, 8'h00, 8'h96};
      vecs[9]  = '{1'b0, 8'h0E, 8'h00, 8'h00};
      vecs[10] = '{1'b1, 8'h20, 8'hFF, 8'h00};
      vecs[11] = '{1'b0, 8'h20, 8'h00, 8'h00};
      vecs[12] = '{1'b1, 8'h00, 8'h77, 8'h00};
      vecs[13] = '{1'b0, 8'h00, 8'h00, 8'h5A};
      vecs[14] = '{1'b1, 8'h09, 8'hC3, 8'h00};
      vecs[15] = '{1'b0, 8'h09, 8'h00, 8'hC3};
      vecs[16] = '{1'b1, 8'h0C, 8'h08, 8'h00};
      vecs[17] = '{1'b0, 8'h0C, 8'h00, 8'h08};

      // Reset state.
      repeat (3) tick();
      check("rst_wait", {63'h0, avs_s0_waitrequest}, 64'd1);
      check("rst_rdv", {63'h0, avs_s0_readdatavalid}, 64'd0);
      check("rst_rdata", {56'h0, avs_s0_readdata}, 64'h0);
      check("rst_ctrl", ctrl_export, 64'h0);
      check("rst_irq_strobe_code", {54'h0, irq, cmd_strobe, cmd_code}, 64'h0);
      reset_reset = 1'b0;
      #1;
      check("wait_low_after_rst", {63'h0, avs_s0_waitrequest}, 64'd0);
      tick();

      // Back-to-back reads of ID and VERSION.
      avs_s0_read = 1'b1;
      avs_s0_address = 8'h00;
      tick();
      avs_s0_address = 8'h01;
      tick();
      avs_s0_read = 1'b0;
      check("b2b_n1_rdv", {63'h0, avs_s0_readdatavalid}, 64'd0);
      tick();
      check("b2b_first", {55'h0, avs_s0_readdatavalid, avs_s0_readdata}, {55'h0, 1'b1, 8'h5A});
      tick();
      check("b2b_second", {55'h0, avs_s0_readdatavalid, avs_s0_readdata}, {55'h0, 1'b1, 8'h01});
      tick();
      check("b2b_end", {63'h0, avs_s0_readdatavalid}, 64'd0);

      // Register map table.
      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            do_write(vecs[i].addr, vecs[i].data);
            if (vecs[i].addr == 8'h05)
               check("ctrl3_next_cycle", {56'h0, ctrl_export[31:24]}, 64'hA5);
         end else begin
            do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
         end
      end
      check("ctrl_export_all", ctrl_export, 64'hC300_0000_A500_0000);

      // Interrupt: rising edge on bit 3 with mask 0x08.
      event_export = 8'h09;
      tick();
      check("irq_delay", {63'h0, irq}, 64'd0);
      tick();
      check("irq_set", {63'h0, irq}, 64'd1);
      do_read("flags_set", 8'h0B, 8'h08);
      event_export = 8'h01;
      tick();
      event_export = 8'h09;
      do_write(8'h0B, 8'h08); // clear coincides with a new edge
      do_read("flags_set_wins", 8'h0B, 8'h08);
      check("irq_still_set", {63'h0, irq}, 64'd1);
      do_write(8'h0B, 8'h08); // clear with no edge
      tick();
      check("irq_cleared", {63'h0, irq}, 64'd0);
      do_read("flags_cleared", 8'h0B, 8'h00);

      // Command stall with a read in flight and a read held throughout.
      wait_ready();
      avs_s0_read = 1'b1;
      avs_s0_address = 8'h00;
      tick();
      avs_s0_read = 1'b0;
      avs_s0_write = 1'b1;
      avs_s0_address = 8'h0E;
      avs_s0_writedata = 8'h3C;
      tick();
      avs_s0_write = 1'b0;
      avs_s0_read = 1'b1;
      avs_s0_address = 8'h0D;
      check("cmd_strobe_hi", {55'h0, cmd_strobe, cmd_code}, {55'h0, 1'b1, 8'h3C});
      cnt = avs_s0_waitrequest ? 1 : 0;
      tick();
      check("stall_inflight_rdv", {55'h0, avs_s0_readdatavalid, avs_s0_readdata}, {55'h0, 1'b1, 8'h5A});
      check("cmd_strobe_one", {55'h0, cmd_strobe, cmd_code}, {55'h0, 1'b0, 8'h3C});
      if (avs_s0_waitrequest) cnt++;
      for (int i = 0; i < 20 && avs_s0_waitrequest; i++) begin
         tick();
         if (avs_s0_waitrequest) cnt++;
      end
      check("cmd_busy_cycles", 64'(cnt), 64'd4);
      tick();
      avs_s0_read = 1'b0;
      collect("held_read", 8'h11);
      check("cmd_code_hold", {56'h0, cmd_code}, 64'h3C);

      // Write right after a read does not alter the data in flight.
      wait_ready();
      avs_s0_read = 1'b1;
      avs_s0_address = 8'h0D;
      tick();
      avs_s0_read = 1'b0;
      avs_s0_write = 1'b1;
      avs_s0_writedata = 8'h22;
      tick();
      avs_s0_write = 1'b0;
      check("inflight_n1", {63'h0, avs_s0_readdatavalid}, 64'd0);
      tick();
      check("inflight_data", {55'h0, avs_s0_readdatavalid, avs_s0_readdata}, {55'h0, 1'b1, 8'h11});
      do_read("scratch_new", 8'h0D, 8'h22);

      // Reset right after a read acceptance discards the return.
      wait_ready();
      avs_s0_read = 1'b1;
      avs_s0_address = 8'h00;
      tick();
      avs_s0_read = 1'b0;
      reset_reset = 1'b1;
      tick();
      tick();
      reset_reset = 1'b0;
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (avs_s0_readdatavalid) cnt++;
      end
      check("rst_abort_no_rdv", 64'(cnt), 64'd0);
      check("rst_abort_ctrl", ctrl_export, 64'h0);

      // Reset in the middle of a command stall cancels it.
      do_write(8'h0E, 8'h99);
      tick();
      reset_reset = 1'b1;
      tick();
      reset_reset = 1'b0;
      #1;
      check("rst_cancel_stall", {63'h0, avs_s0_waitrequest}, 64'd0);
      check("rst_code_clear", {55'h0, cmd_strobe, cmd_code}, 64'h0);
      do_read("after_cancel", 8'h01, 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/avmm_reg_slave.md
AVMM_REG_SLAVE -- requirements
Module: avmm_reg_slave

Interface
REQ-001 Parameters SHALL be, one per line:
- VERSION, 8'h01, value returned at address 0x01.
- CMD_BUSY, 4, stall cycles after a CMD write; legal range 1..15.

REQ-002 Ports SHALL be, one per line:
- clk_clk  in  1  single clock; all logic rising-edge.
- reset_reset  in  1  synchronous, active-high reset.
- avs_s0_address  in  8  word address.
- avs_s0_read  in  1  read request.
- avs_s0_write  in  1  write request.
- avs_s0_writedata  in  8  write data.
- avs_s0_waitrequest  out  1  stall; request accepted only when low.
- avs_s0_readdata  out  8  read data, qualified by readdatavalid.
- avs_s0_readdatavalid  out  1  read data valid.
- ctrl_export  out  64  CTRL0..CTRL7 concatenated, CTRL0 in [7:0].
- status_export  in  8  live status levels.
- event_export  in  8  event levels, rising-edge sensitive.
- irq  out  1  interrupt, level.
- cmd_strobe  out  1  one-cycle command pulse.
- cmd_code  out  8  command value, valid with cmd_strobe.

REQ-003 The block SHALL use one clock (clk_clk) and a synchronous, active-high reset (reset_reset).

Function
REQ-004 Accept rule: a read or write SHALL be accepted in a cycle where it is high and avs_s0_waitrequest is low. Simultaneous read and write are illegal; the write SHALL take priority and the read SHALL be dropped.
REQ-005 Register map SHALL be:
- 0x00 ID, RO, 0x5A.
- 0x01 VERSION, RO.
- 0x02-0x09 CTRL0-7, RW.
- 0x0A STATUS, RO.
- 0x0B IRQ_FLAGS, W1C.
- 0x0C IRQ_MASK, RW.
- 0x0D SCRATCH, RW.
- 0x0E CMD, WO, reads 0x00.
- All other addresses SHALL read 0x00 and ignore writes.
REQ-006 An accepted write SHALL update the target register on the same clock edge; the new value is visible on ctrl_export the next cycle.
REQ-007 Read latency SHALL be exactly 2 cycles: a read accepted at edge N gives readdatavalid high for one cycle after edge N+2.
REQ-008 Read data SHALL be captured at acceptance. A write in the following cycle SHALL NOT alter data already in flight.
REQ-009 Back-to-back reads SHALL be accepted every cycle when not stalled. Data SHALL return in order, one per cycle.
REQ-010 STATUS SHALL return status_export registered once (1-cycle sample delay).
REQ-011 IRQ_FLAGS bit i SHALL set when event_export[i] is high and was low the previous cycle.
- Writing 1 clears the bit; writing 0 has no effect.
- If set and clear hit the same bit in the same cycle, set wins.
REQ-012 irq SHALL be registered: irq = OR(IRQ_FLAGS & IRQ_MASK), 1 cycle after the flags or mask change.
REQ-013 An accepted CMD write at edge N SHALL cause:
- cmd_strobe high for exactly the cycle after N, with cmd_code = writedata;
- waitrequest high for exactly CMD_BUSY cycles starting the cycle after N.
REQ-014 During a stall, in-flight readdatavalid SHALL still complete on schedule. Held requests SHALL be accepted the first cycle waitrequest is low.
REQ-015 cmd_code SHALL hold its last value between strobes.

Reset
REQ-016 While reset_reset is high, the following SHALL hold:
- waitrequest = 1;
- readdatavalid = 0, readdata = 0x00;
- CTRL0-7, IRQ_FLAGS, IRQ_MASK and SCRATCH = 0x00;
- irq = 0, cmd_strobe = 0, cmd_code = 0x00;
- busy counter = 0;
- event history = 0xFF, so levels already high at reset release do not set flags.
REQ-017 waitrequest SHALL be low the first cycle after reset_reset deasserts.
REQ-018 Reset mid-operation SHALL discard pending read returns (no readdatavalid afterwards) and cancel any CMD stall.

Verification
REQ-019 Reset, then read 0x00 and 0x01 back-to-back -> readdatavalid after edges N+2 and N+3, with data 0x5A then 0x01.
REQ-020 Write 0xA5 to 0x05 -> ctrl_export[31:24] = 0xA5 the next cycle; readback returns 0xA5; other CTRL bytes stay 0x00.
REQ-021 event_export[3] rises with IRQ_MASK = 0x08 -> IRQ_FLAGS = 0x08 and irq = 1. Write 0x08 to 0x0B on the same cycle as a new rising edge on bit 3 -> flag stays set. A later clear with no edge -> irq = 0.
REQ-022 Write 0x3C to 0x0E with CMD_BUSY = 4 -> cmd_strobe high for 1 cycle with cmd_code = 0x3C; waitrequest high for 4 cycles; a read held throughout is accepted on cycle 5 after the write.
REQ-023 Accept a read of 0x0D (SCRATCH = 0x11), then write 0x22 to it next cycle -> returned data = 0x11; assert reset on the edge right after a read is accepted -> no readdatavalid ever appears.
